// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and lane helpers for the bank access arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {SIZE_B, SIZE_H, SIZE_W} mem_size_t;
    typedef enum logic {IDLE, SPLIT} arb_state_t;
    typedef enum logic {GNT_IF, GNT_LS} grant_t;

    // Size code 3 is treated as a word access.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (mem_size_t'(size))
            SIZE_B:  return 3'd1;
            SIZE_H:  return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Bytes that spill past lane 3 land in the upper nibble and form the second beat.
    function automatic logic [3:0] lane_mask(input logic [1:0] offset, input logic [1:0] size,
                                             input logic beat);
        logic [7:0] m;
        m = ((8'd1 << size_bytes(size)) - 8'd1) << offset;
        return beat ? m[7:4] : m[3:0];
    endfunction

    function automatic logic crosses_row(input logic [1:0] offset, input logic [1:0] size);
        return ({1'b0, offset} + size_bytes(size)) > 3'd4;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane rotation, beat merge and zero fill
module mem_lane_align
    import mem_arb_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        second_beat,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    input  logic [31:0] partial,
    output logic [31:0] wdata_rot,
    output logic [31:0] rdata_out
);

    logic [3:0]  m2;
    logic [2:0]  n;
    logic [31:0] merged;
    logic [1:0]  wsrc;
    logic [1:0]  rsrc;

    always_comb begin
        m2        = lane_mask(offset, size, 1'b1);
        n         = size_bytes(size);
        wdata_rot = '0;
        merged    = '0;
        rdata_out = '0;
        wsrc      = '0;
        rsrc      = '0;
        // Lane j of a beat carries request byte (j - offset) mod 4 in both directions.
        for (int j = 0; j < 4; j++) begin
            wsrc = 2'(j) - offset;
            wdata_rot[8*j +: 8] = wdata[{wsrc, 3'b000} +: 8];
            merged[8*j +: 8]    = (second_beat && !m2[j]) ? partial[8*j +: 8] : rdata[8*j +: 8];
        end
        for (int k = 0; k < 4; k++) begin
            rsrc = 2'(k) + offset;
            rdata_out[8*k +: 8] = (3'(k) < n) ? merged[{rsrc, 3'b000} +: 8] : 8'h00;
        end
    end

endmodule

// File: rtl/bank_access_arbiter.sv
// rtl/bank_access_arbiter.sv - round-robin IF/LS arbiter for a 4-lane byte-banked memory
module bank_access_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int DATA_DEPTH = 4096,
    localparam int ROW_W      = $clog2(DATA_DEPTH),
    localparam int ADDR_W     = ROW_W + 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_rsp_valid,
    output logic [31:0]       if_rsp_data,
    input  logic              ls_req_valid,
    output logic              ls_req_ready,
    input  logic              ls_we,
    input  logic [1:0]        ls_size,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_rsp_valid,
    output logic [31:0]       ls_rsp_data,
    output logic [ROW_W-1:0]  mem_raddr,
    input  logic [31:0]       mem_rdata,
    output logic [ROW_W-1:0]  mem_waddr,
    output logic [3:0]        mem_we,
    output logic [31:0]       mem_wdata
);

    arb_state_t       state;
    grant_t           last_grant;
    logic [ROW_W-1:0] split_row;
    logic [1:0]       split_off;
    logic [1:0]       split_size;
    logic             split_we;
    logic [31:0]      split_wdata;
    logic [31:0]      partial;

    logic [ROW_W-1:0] cur_row;
    logic [ROW_W-1:0] next_row;
    logic [1:0]       cur_off;
    logic [1:0]       cur_size;
    logic             cur_we;
    logic [31:0]      cur_wdata;
    logic             beat2;
    logic             active;
    logic [31:0]      aligned;

    assign if_req_ready = !rst && (state == IDLE) && if_req_valid
                          && (!ls_req_valid || last_grant == GNT_LS);
    assign ls_req_ready = !rst && (state == IDLE) && ls_req_valid
                          && (!if_req_valid || last_grant == GNT_IF);

    // Select the beat presented to the banks this cycle.
    always_comb begin
        cur_row   = ls_addr[ADDR_W-1:2];
        cur_off   = ls_addr[1:0];
        cur_size  = ls_size;
        cur_we    = ls_we;
        cur_wdata = ls_wdata;
        beat2     = 1'b0;
        active    = ls_req_ready;
        if (state == SPLIT) begin
            cur_row   = split_row;
            cur_off   = split_off;
            cur_size  = split_size;
            cur_we    = split_we;
            cur_wdata = split_wdata;
            beat2     = 1'b1;
            active    = !rst;
        end else if (if_req_ready) begin
            cur_row   = if_addr[ADDR_W-1:2];
            cur_off   = 2'd0;
            cur_size  = SIZE_W;
            cur_we    = 1'b0;
            cur_wdata = '0;
            active    = 1'b1;
        end
    end

    assign next_row  = (cur_row == ROW_W'(DATA_DEPTH - 1)) ? '0 : cur_row + ROW_W'(1);
    assign mem_raddr = cur_row;
    assign mem_waddr = cur_row;
    assign mem_we    = (active && cur_we) ? lane_mask(cur_off, cur_size, beat2) : 4'b0000;

    mem_lane_align u_align (
        .offset      (cur_off),
        .size        (cur_size),
        .second_beat (beat2),
        .wdata       (cur_wdata),
        .rdata       (mem_rdata),
        .partial     (partial),
        .wdata_rot   (mem_wdata),
        .rdata_out   (aligned)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            last_grant   <= GNT_LS;
            if_rsp_valid <= 1'b0;
            if_rsp_data  <= '0;
            ls_rsp_valid <= 1'b0;
            ls_rsp_data  <= '0;
            partial      <= '0;
            split_row    <= '0;
            split_off    <= '0;
            split_size   <= '0;
            split_we     <= 1'b0;
            split_wdata  <= '0;
        end else begin
            if_rsp_valid <= 1'b0;
            ls_rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (if_req_ready) begin
                        last_grant   <= GNT_IF;
                        if_rsp_valid <= 1'b1;
                        if_rsp_data  <= aligned;
                    end else if (ls_req_ready) begin
                        last_grant <= GNT_LS;
                        if (crosses_row(cur_off, cur_size)) begin
                            state       <= SPLIT;
                            split_row   <= next_row;
                            split_off   <= cur_off;
                            split_size  <= cur_size;
                            split_we    <= cur_we;
                            split_wdata <= cur_wdata;
                            partial     <= mem_rdata;
                        end else begin
                            ls_rsp_valid <= 1'b1;
                            ls_rsp_data  <= cur_we ? 32'h0 : aligned;
                        end
                    end
                end
                SPLIT: begin
                    state        <= IDLE;
                    ls_rsp_valid <= 1'b1;
                    ls_rsp_data  <= split_we ? 32'h0 : aligned;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bank_access_arbiter.sv
// tb/tb_bank_access_arbiter.sv - randomized self-checking bench for bank_access_arbiter
module tb_bank_access_arbiter;

    localparam int DEPTH = 4096;
    localparam int MEMB  = 4 * DEPTH;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req_valid = 1'b0;
    logic        if_req_ready;
    logic [13:0] if_addr = '0;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_data;
    logic        ls_req_valid = 1'b0;
    logic        ls_req_ready;
    logic        ls_we = 1'b0;
    logic [1:0]  ls_size = '0;
    logic [13:0] ls_addr = '0;
    logic [31:0] ls_wdata = '0;
    logic        ls_rsp_valid;
    logic [31:0] ls_rsp_data;
    logic [11:0] mem_raddr;
    logic [31:0] mem_rdata;
    logic [11:0] mem_waddr;
    logic [3:0]  mem_we;
    logic [31:0] mem_wdata;

    int errors = 0;
    int checks = 0;

    logic [7:0]  ref_mem [MEMB];
    logic [7:0]  bank [4][DEPTH];
    logic [11:0] wl_row [$];
    logic [3:0]  wl_we [$];
    logic [31:0] wl_data [$];

    bank_access_arbiter #(.DATA_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_we(ls_we),
        .ls_size(ls_size), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .mem_waddr(mem_waddr),
        .mem_we(mem_we), .mem_wdata(mem_wdata)
    );

    always #5 clk = ~clk;

    always_comb begin
        mem_rdata = '0;
        for (int i = 0; i < 4; i++) mem_rdata[8*i +: 8] = bank[i][mem_raddr];
    end

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (mem_we[i]) bank[i][mem_waddr] <= mem_wdata[8*i +: 8];
    end

    always @(negedge clk) begin
        if (mem_we != 4'b0000) begin
            wl_row.push_back(mem_waddr);
            wl_we.push_back(mem_we);
            wl_data.push_back(mem_wdata);
        end
    end

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input int addr, input logic [1:0] s);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < nbytes(s); k++) r[8*k +: 8] = ref_mem[(addr + k) % MEMB];
        return r;
    endfunction

    function automatic int ref_lat(input int addr, input logic [1:0] s);
        return ((addr % 4) + nbytes(s) > 4) ? 2 : 1;
    endfunction

    task automatic ref_store(input int addr, input logic [1:0] s, input logic [31:0] wd);
        for (int k = 0; k < nbytes(s); k++) ref_mem[(addr + k) % MEMB] = wd[8*k +: 8];
    endtask

    task automatic clear_log();
        wl_row.delete();
        wl_we.delete();
        wl_data.delete();
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Drive one LS request; lat = cycles from accept edge to response, -1 if never accepted.
    task automatic ls_xfer(input logic we, input logic [1:0] sz, input int addr, input logic [31:0] wd,
                           output logic [31:0] rd, output int lat);
        bit acc;
        int n;
        ls_we = we; ls_size = sz; ls_addr = 14'(addr); ls_wdata = wd; ls_req_valid = 1'b1;
        acc = 1'b0; n = 0;
        while (!acc && n < 20) begin
            @(negedge clk); acc = ls_req_ready;
            @(posedge clk); #1; n++;
        end
        ls_req_valid = 1'b0;
        rd = '0; lat = acc ? 0 : -1;
        if (acc)
            for (int c = 1; c <= 4 && lat == 0; c++) begin
                if (ls_rsp_valid) begin lat = c; rd = ls_rsp_data; end
                else begin @(posedge clk); #1; end
            end
    endtask

    task automatic if_xfer(input int addr, output logic [31:0] rd, output int lat);
        bit acc;
        int n;
        if_addr = 14'(addr); if_req_valid = 1'b1;
        acc = 1'b0; n = 0;
        while (!acc && n < 20) begin
            @(negedge clk); acc = if_req_ready;
            @(posedge clk); #1; n++;
        end
        if_req_valid = 1'b0;
        rd = '0; lat = acc ? 0 : -1;
        if (acc)
            for (int c = 1; c <= 4 && lat == 0; c++) begin
                if (if_rsp_valid) begin lat = c; rd = if_rsp_data; end
                else begin @(posedge clk); #1; end
            end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        if_req_valid = 1'b1; ls_req_valid = 1'b1; ls_we = 1'b1; ls_size = 2'd2;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({if_req_ready, ls_req_ready} !== 2'b00) begin
            errors++; $display("FAIL reset_ready: got %b expected 00", {if_req_ready, ls_req_ready});
        end
        checks++;
        if (mem_we !== 4'b0000) begin
            errors++; $display("FAIL reset_mem_we: got %h expected 0", mem_we);
        end
        checks++;
        if ({if_rsp_valid, ls_rsp_valid} !== 2'b00 || if_rsp_data !== 32'h0 || ls_rsp_data !== 32'h0) begin
            errors++; $display("FAIL reset_rsp: got v=%b if=%h ls=%h expected 00/0/0",
                               {if_rsp_valid, ls_rsp_valid}, if_rsp_data, ls_rsp_data);
        end
        if_req_valid = 1'b0; ls_req_valid = 1'b0; ls_we = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_store_load_word();
        logic [31:0] rd; int lat;
        clear_log();
        ls_xfer(1'b1, 2'd2, 32'h10, 32'hDEADBEEF, rd, lat);
        ref_store(32'h10, 2'd2, 32'hDEADBEEF);
        checks++;
        if (wl_we.size() != 1 || wl_we[0] !== 4'hF || wl_row[0] !== 12'd4 || wl_data[0] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL t1_write: n=%0d we=%h row=%0d data=%h expected 1/f/4/deadbeef",
                               wl_we.size(), wl_we[0], wl_row[0], wl_data[0]);
        end
        checks++;
        if (lat !== 1 || rd !== 32'h0) begin
            errors++; $display("FAIL t1_store_rsp: lat=%0d data=%h expected 1/0", lat, rd);
        end
        ls_xfer(1'b0, 2'd2, 32'h10, 32'h0, rd, lat);
        checks++;
        if (lat !== 1 || rd !== 32'hDEADBEEF) begin
            errors++; $display("FAIL t1_load: lat=%0d data=%h expected 1/deadbeef", lat, rd);
        end
    endtask

    task automatic test_split_half();
        logic [31:0] rd; int lat;
        clear_log();
        ls_xfer(1'b1, 2'd1, 32'h0B, 32'h0000A55A, rd, lat);
        ref_store(32'h0B, 2'd1, 32'h0000A55A);
        checks++;
        if (wl_we.size() != 2 || wl_row[0] !== 12'd2 || wl_we[0] !== 4'b1000 || wl_data[0][31:24] !== 8'h5A
            || wl_row[1] !== 12'd3 || wl_we[1] !== 4'b0001 || wl_data[1][7:0] !== 8'hA5) begin
            errors++; $display("FAIL t2_beats: n=%0d b1=%0d/%b/%h b2=%0d/%b/%h expected 2/1000/5a.. 3/0001/..a5",
                               wl_we.size(), wl_row[0], wl_we[0], wl_data[0], wl_row[1], wl_we[1], wl_data[1]);
        end
        checks++;
        if (lat !== 2) begin
            errors++; $display("FAIL t2_store_lat: got %0d expected 2", lat);
        end
        ls_xfer(1'b0, 2'd2, 32'h08, 32'h0, rd, lat);
        checks++;
        if (lat !== 1 || rd[31:24] !== 8'h5A || rd !== ref_load(32'h08, 2'd2)) begin
            errors++; $display("FAIL t2_load: lat=%0d data=%h expected 1/%h", lat, rd, ref_load(32'h08, 2'd2));
        end
    endtask

    task automatic test_zero_extend();
        logic [31:0] rd; int lat;
        ls_xfer(1'b1, 2'd0, 32'h07, 32'hFFFFFF80, rd, lat);
        ref_store(32'h07, 2'd0, 32'hFFFFFF80);
        ls_xfer(1'b0, 2'd0, 32'h07, 32'h0, rd, lat);
        checks++;
        if (lat !== 1 || rd !== 32'h00000080) begin
            errors++; $display("FAIL t3_zext: lat=%0d data=%h expected 1/00000080", lat, rd);
        end
    endtask

    task automatic test_alternate();
        logic [1:0] exp_g;
        apply_reset();
        if_addr = 14'h20; ls_we = 1'b0; ls_size = 2'd2; ls_addr = 14'h30;
        if_req_valid = 1'b1; ls_req_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            exp_g = (c % 2 == 0) ? 2'b10 : 2'b01;
            @(negedge clk);
            checks++;
            if ({if_req_ready, ls_req_ready} !== exp_g) begin
                errors++; $display("FAIL t4_grant%0d: got %b expected %b", c, {if_req_ready, ls_req_ready}, exp_g);
            end
            @(posedge clk); #1;
            checks++;
            if ({if_rsp_valid, ls_rsp_valid} !== exp_g
                || (exp_g[1] && if_rsp_data !== ref_load(32'h20, 2'd2))
                || (exp_g[0] && ls_rsp_data !== ref_load(32'h30, 2'd2))) begin
                errors++; $display("FAIL t4_rsp%0d: valid=%b if=%h ls=%h expected %b/%h/%h", c,
                                   {if_rsp_valid, ls_rsp_valid}, if_rsp_data, ls_rsp_data, exp_g,
                                   ref_load(32'h20, 2'd2), ref_load(32'h30, 2'd2));
            end
        end
        if_req_valid = 1'b0; ls_req_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_wrap();
        logic [31:0] rd; int lat;
        int a;
        a = MEMB - 2;
        clear_log();
        ls_xfer(1'b1, 2'd2, a, 32'h44332211, rd, lat);
        ref_store(a, 2'd2, 32'h44332211);
        checks++;
        if (wl_we.size() != 2 || wl_row[0] !== 12'(DEPTH - 1) || wl_we[0] !== 4'b1100
            || wl_row[1] !== 12'd0 || wl_we[1] !== 4'b0011 || lat !== 2) begin
            errors++; $display("FAIL t5_wrap: n=%0d b1=%0d/%b b2=%0d/%b lat=%0d expected 2 %0d/1100 0/0011 2",
                               wl_we.size(), wl_row[0], wl_we[0], wl_row[1], wl_we[1], lat, DEPTH - 1);
        end
        ls_xfer(1'b0, 2'd2, a, 32'h0, rd, lat);
        checks++;
        if (lat !== 2 || rd !== 32'h44332211) begin
            errors++; $display("FAIL t5_readback: lat=%0d data=%h expected 2/44332211", lat, rd);
        end
    endtask

    task automatic test_reset_mid_split();
        logic [31:0] rd; int lat;
        bit saw_rsp;
        saw_rsp = 1'b0;
        ls_we = 1'b0; ls_size = 2'd2; ls_addr = 14'h13; ls_req_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (ls_req_ready !== 1'b1) begin
            errors++; $display("FAIL t6_accept: got %b expected 1", ls_req_ready);
        end
        @(posedge clk); #1;
        ls_req_valid = 1'b0;
        rst = 1'b1;
        if_req_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (ls_rsp_valid) saw_rsp = 1'b1;
            checks++;
            if ({if_req_ready, ls_req_ready, mem_we} !== 6'b0) begin
                errors++; $display("FAIL t6_in_reset: ready=%b we=%b expected 00/0000",
                                   {if_req_ready, ls_req_ready}, mem_we);
            end
        end
        if_req_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (ls_rsp_valid) saw_rsp = 1'b1;
        end
        checks++;
        if (saw_rsp) begin
            errors++; $display("FAIL t6_no_rsp: got ls_rsp_valid=1 expected 0");
        end
        @(posedge clk); #1;
        if_xfer(32'h40, rd, lat);
        checks++;
        if (lat !== 1 || rd !== ref_load(32'h40, 2'd2)) begin
            errors++; $display("FAIL t6_fetch: lat=%0d data=%h expected 1/%h", lat, rd, ref_load(32'h40, 2'd2));
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, wd; int lat, a, op;
        logic [1:0] sz;
        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 3);
            a  = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 63) : MEMB - 8 + $urandom_range(0, 7);
            sz = 2'($urandom_range(0, 3));
            wd = $urandom;
            if (op == 0) begin
                ls_xfer(1'b1, sz, a, wd, rd, lat);
                checks++;
                if (lat !== ref_lat(a, sz) || rd !== 32'h0) begin
                    errors++; $display("FAIL rnd_store%0d: addr=%h sz=%0d lat=%0d data=%h expected %0d/0",
                                       i, a, sz, lat, rd, ref_lat(a, sz));
                end
                ref_store(a, sz, wd);
            end else if (op == 3) begin
                if_xfer(a, rd, lat);
                checks++;
                if (lat !== 1 || rd !== ref_load(a & ~3, 2'd2)) begin
                    errors++; $display("FAIL rnd_fetch%0d: addr=%h lat=%0d data=%h expected 1/%h",
                                       i, a, lat, rd, ref_load(a & ~3, 2'd2));
                end
            end else begin
                ls_xfer(1'b0, sz, a, 32'h0, rd, lat);
                checks++;
                if (lat !== ref_lat(a, sz) || rd !== ref_load(a, sz)) begin
                    errors++; $display("FAIL rnd_load%0d: addr=%h sz=%0d lat=%0d data=%h expected %0d/%h",
                                       i, a, sz, lat, rd, ref_lat(a, sz), ref_load(a, sz));
                end
            end
        end
    endtask

    initial begin
        for (int a = 0; a < MEMB; a++) begin
            ref_mem[a] = 8'($urandom);
            bank[a % 4][a / 4] = ref_mem[a];
        end
        test_reset();
        test_store_load_word();
        test_split_half();
        test_zero_extend();
        test_alternate();
        test_wrap();
        test_reset_mid_split();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
